// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and fills the IF/ID register.
// Boot takes one idle cycle with the ROM disabled. Redirect priority is flush > stall > branch.
// A taken branch still captures its delay-slot instruction.
// Optional FETCH_ALIGN_CHECK_EN: keeps misaligned redirect targets and reports them on id_adel_o.
// Without it, redirect targets are forced to word alignment.
module if_pc_stage #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INST_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [INST_W-1:0]   NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              id_adel_o,
`endif
  output logic              id_valid_o
);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rom_ce_q, rom_ce_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              mis_q, mis_d;
  logic              adel_q, adel_d;
`endif

  // Address actually loaded into the PC on a flush or branch redirect.
  function automatic logic [ADDR_W-1:0] redirect_pc(input logic [ADDR_W-1:0] target);
`ifdef FETCH_ALIGN_CHECK_EN
    return target;
`else
    return target & AlignMask;
`endif
  endfunction

  // Next-state logic: boot sequencing, then flush > stall > branch > sequential fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rom_ce_d   = rom_ce_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_d      = mis_q;
    adel_d     = adel_q;
`endif
    case (state_q)
      StBoot: begin
        // ROM is disabled this cycle, so nothing is captured; only a flush can move the PC.
        state_d  = StRun;
        rom_ce_d = 1'b1;
        if (flush_i) begin
          pc_d = redirect_pc(new_pc_i);
`ifdef FETCH_ALIGN_CHECK_EN
          mis_d = |new_pc_i[1:0];
`endif
        end
      end
      StRun: begin
        rom_ce_d = 1'b1;
        if (flush_i) begin
          pc_d       = redirect_pc(new_pc_i);
          id_pc_d    = '0;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          mis_d  = |new_pc_i[1:0];
          adel_d = 1'b0;
`endif
        end else if (!stall_i) begin
          id_pc_d    = pc_q;
          id_inst_d  = rom_inst_i;
          id_valid_d = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
          // A misaligned fetch delivers a NOP tagged with the address-error flag.
          if (mis_q) begin
            id_inst_d = NOP_INST;
            adel_d    = 1'b1;
          end else begin
            adel_d    = 1'b0;
          end
`endif
          if (branch_flag_i) begin
            pc_d = redirect_pc(branch_target_i);
`ifdef FETCH_ALIGN_CHECK_EN
            if (|branch_target_i[1:0]) begin
              mis_d = 1'b1;
            end
`endif
          end else begin
            pc_d = pc_q + ADDR_W'(4);
          end
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      rom_ce_q   <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q      <= 1'b0;
      adel_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_ce_q   <= rom_ce_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q      <= mis_d;
      adel_q     <= adel_d;
`endif
    end
  end

  assign rom_ce_o   = rom_ce_q;
  assign rom_addr_o = pc_q;
  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign id_adel_o  = adel_q;
`endif

endmodule
